// File: rtl/memory_cycle_if.sv
// rtl/memory_cycle_if.sv - E/M inputs and M/W outputs of the memory stage
// master drives the E/M bundle and observes W; slave is the memory stage itself.
interface memory_cycle_if;
  logic [31:0] ALUResultM;
  logic [31:0] WriteDataM;
  logic [31:0] PCPlus4M;
  logic [31:0] InstrM;
  logic [4:0]  RdM;
  logic        RegWriteM;
  logic        MemWriteM;
  logic [1:0]  ResultSrcM;

  logic [31:0] ALUResultW;
  logic [31:0] ReadDataW;
  logic [31:0] PCPlus4W;
  logic [4:0]  RdW;
  logic        RegWriteW;
  logic [1:0]  ResultSrcW;
  logic [31:0] ResultW;
  logic        MisalignW;

  modport master (
    output ALUResultM, WriteDataM, PCPlus4M, InstrM, RdM, RegWriteM, MemWriteM, ResultSrcM,
    input  ALUResultW, ReadDataW, PCPlus4W, RdW, RegWriteW, ResultSrcW, ResultW, MisalignW
  );

  modport slave (
    input  ALUResultM, WriteDataM, PCPlus4M, InstrM, RdM, RegWriteM, MemWriteM, ResultSrcM,
    output ALUResultW, ReadDataW, PCPlus4W, RdW, RegWriteW, ResultSrcW, ResultW, MisalignW
  );
endinterface

// File: rtl/memory_cycle.sv
// rtl/memory_cycle.sv - RISC-V memory stage: byte/half/word data memory access and M/W register
// Optional MISALIGN_CHECK_EN: flag misaligned half/word accesses, drop such stores, kill such loads.
module memory_cycle #(
  parameter int DMEM_DEPTH = 1024
) (
  input logic           clk,
  input logic           rst,
  memory_cycle_if.slave bus
);
  localparam int AW = $clog2(DMEM_DEPTH);

  logic [31:0]   dmem [DMEM_DEPTH];
  logic [2:0]    funct3;
  logic [AW-1:0] wordIdx;
  logic          isLoad;
  logic          isHalf;
  logic          isWord;
  logic          misalignM;
  logic [1:0]    lane;
  logic [31:0]   rdWord;
  logic [7:0]    rdByte;
  logic [15:0]   rdHalf;
  logic [31:0]   loadExt;
  logic [3:0]    byteEn;
  logic [31:0]   wrData;
  logic          unusedBits;

  assign funct3  = bus.InstrM[14:12];
  assign wordIdx = bus.ALUResultM[AW+1:2];
  assign isLoad  = (bus.ResultSrcM == 2'b01);
  assign isHalf  = (funct3 == 3'b001) || (isLoad && funct3 == 3'b101);
  assign isWord  = (funct3 == 3'b010);

  // Low address bits below the access size are dropped, so lanes are always naturally aligned.
  assign lane = isWord ? 2'b00 : (isHalf ? {bus.ALUResultM[1], 1'b0} : bus.ALUResultM[1:0]);

`ifdef MISALIGN_CHECK_EN
  logic accessM;
  assign accessM   = isLoad || bus.MemWriteM;
  assign misalignM = accessM && ((isHalf && bus.ALUResultM[0]) ||
                                 (isWord && bus.ALUResultM[1:0] != 2'b00));
`else
  assign misalignM = 1'b0;
`endif

  assign unusedBits = ^{bus.InstrM[31:15], bus.InstrM[11:0], bus.ALUResultM[31:AW+2]};

  assign rdWord = dmem[wordIdx];
  assign rdByte = rdWord[{lane, 3'b000} +: 8];
  assign rdHalf = lane[1] ? rdWord[31:16] : rdWord[15:0];

  always_comb begin
    loadExt = 32'h0;
    case (funct3)
      3'b000:  loadExt = {{24{rdByte[7]}}, rdByte};
      3'b001:  loadExt = {{16{rdHalf[15]}}, rdHalf};
      3'b010:  loadExt = rdWord;
      3'b100:  loadExt = {24'h0, rdByte};
      3'b101:  loadExt = {16'h0, rdHalf};
      default: loadExt = 32'h0;
    endcase
  end

  // Reset gates the write enables so a store caught in M while reset is low never lands.
  always_comb begin
    byteEn = 4'b0000;
    wrData = bus.WriteDataM;
    if (rst && bus.MemWriteM && !misalignM) begin
      case (funct3)
        3'b000: begin
          byteEn = 4'b0001 << lane;
          wrData = {4{bus.WriteDataM[7:0]}};
        end
        3'b001: begin
          byteEn = lane[1] ? 4'b1100 : 4'b0011;
          wrData = {2{bus.WriteDataM[15:0]}};
        end
        3'b010:  byteEn = 4'b1111;
        default: byteEn = 4'b0000;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (byteEn[b]) begin
        dmem[wordIdx][8*b +: 8] <= wrData[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.ALUResultW <= 32'h0;
      bus.ReadDataW  <= 32'h0;
      bus.PCPlus4W   <= 32'h0;
      bus.RdW        <= 5'd0;
      bus.RegWriteW  <= 1'b0;
      bus.ResultSrcW <= 2'b00;
      bus.MisalignW  <= 1'b0;
    end else begin
      bus.ALUResultW <= bus.ALUResultM;
      bus.ReadDataW  <= loadExt;
      bus.PCPlus4W   <= bus.PCPlus4M;
      bus.RdW        <= bus.RdM;
      bus.RegWriteW  <= bus.RegWriteM && !(misalignM && isLoad);
      bus.ResultSrcW <= bus.ResultSrcM;
      bus.MisalignW  <= misalignM;
    end
  end

  always_comb begin
    bus.ResultW = 32'h0;
    case (bus.ResultSrcW)
      2'b00:   bus.ResultW = bus.ALUResultW;
      2'b01:   bus.ResultW = bus.ReadDataW;
      2'b10:   bus.ResultW = bus.PCPlus4W;
      default: bus.ResultW = 32'h0;
    endcase
  end
endmodule

// File: tb/tb_memory_cycle.sv
// tb/tb_memory_cycle.sv - scoreboard bench for memory_cycle
// Directed vectors push expected W values; a monitor pops and compares one cycle later.
module tb_memory_cycle;
  localparam int DEPTH = 1024;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    logic        rw;
    logic        mis;
    logic        chkRes;
    string       name;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   passed = 0;
  int   total = 0;
  exp_t q[$];

  memory_cycle_if bus ();

  memory_cycle #(.DMEM_DEPTH(DEPTH)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] expv);
    total++;
    if (act === expv) passed++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, expv);
  endfunction

  task automatic drive(input logic [2:0] f3, input logic [1:0] src, input logic [31:0] alu,
                       input logic [31:0] wd, input logic [31:0] pc, input logic [4:0] rd,
                       input logic rw, input logic mw);
    @(posedge clk);
    #1;
    bus.InstrM     = {17'h0, f3, 12'h0};
    bus.ResultSrcM = src;
    bus.ALUResultM = alu;
    bus.WriteDataM = wd;
    bus.PCPlus4M   = pc;
    bus.RdM        = rd;
    bus.RegWriteM  = rw;
    bus.MemWriteM  = mw;
  endtask

  task automatic push(input string nm, input logic [31:0] res, input logic [4:0] rd,
                      input logic rw, input logic mis, input logic chkRes);
    exp_t e;
    e.res = res; e.rd = rd; e.rw = rw; e.mis = mis; e.chkRes = chkRes; e.name = nm;
    q.push_back(e);
  endtask

  task automatic st(input string nm, input logic [2:0] f3, input logic [31:0] addr,
                    input logic [31:0] data, input logic mis);
    drive(f3, 2'b00, addr, data, 32'h0, 5'd0, 1'b0, 1'b1);
    push(nm, addr, 5'd0, 1'b0, mis, 1'b1);
  endtask

  task automatic ld(input string nm, input logic [2:0] f3, input logic [31:0] addr,
                    input logic [4:0] rd, input logic [31:0] res, input logic rw,
                    input logic mis, input logic chkRes);
    drive(f3, 2'b01, addr, 32'h0, 32'h0, rd, 1'b1, 1'b0);
    push(nm, res, rd, rw, mis, chkRes);
  endtask

  task automatic op(input string nm, input logic [1:0] src, input logic [31:0] alu,
                    input logic [31:0] pc, input logic [4:0] rd, input logic [31:0] res);
    drive(3'b000, src, alu, 32'h0, pc, rd, 1'b1, 1'b0);
    push(nm, res, rd, 1'b1, 1'b0, 1'b1);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      if (q.size() != 0) begin
        e = q.pop_front();
        @(negedge clk);
        if (e.chkRes) chk({e.name, ".ResultW"}, bus.ResultW, e.res);
        chk({e.name, ".RdW"}, {27'h0, bus.RdW}, {27'h0, e.rd});
        chk({e.name, ".RegWriteW"}, {31'h0, bus.RegWriteW}, {31'h0, e.rw});
        chk({e.name, ".MisalignW"}, {31'h0, bus.MisalignW}, {31'h0, e.mis});
      end
    end
  end

  initial begin
    bus.InstrM     = {17'h0, 3'b010, 12'h0};
    bus.ResultSrcM = 2'b00;
    bus.ALUResultM = 32'h10;
    bus.WriteDataM = 32'hDEADBEEF;
    bus.PCPlus4M   = 32'h44;
    bus.RdM        = 5'd3;
    bus.RegWriteM  = 1'b1;
    bus.MemWriteM  = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst.ALUResultW", bus.ALUResultW, 32'h0);
    chk("rst.ReadDataW", bus.ReadDataW, 32'h0);
    chk("rst.PCPlus4W", bus.PCPlus4W, 32'h0);
    chk("rst.RdW", {27'h0, bus.RdW}, 32'h0);
    chk("rst.RegWriteW", {31'h0, bus.RegWriteW}, 32'h0);
    chk("rst.ResultSrcW", {30'h0, bus.ResultSrcW}, 32'h0);
    chk("rst.MisalignW", {31'h0, bus.MisalignW}, 32'h0);
    chk("rst.ResultW", bus.ResultW, 32'h0);
    bus.MemWriteM = 1'b0;
    #1 rst = 1'b1;

    ld("lw10_after_rst", 3'b010, 32'h10, 5'd1, 32'h00000000, 1'b1, 1'b0, 1'b1);

    st("sw20", 3'b010, 32'h20, 32'h8899AABB, 1'b0);
    ld("lb21", 3'b000, 32'h21, 5'd2, 32'hFFFFFFAA, 1'b1, 1'b0, 1'b1);
    ld("lbu23", 3'b100, 32'h23, 5'd3, 32'h00000088, 1'b1, 1'b0, 1'b1);
    ld("lh22", 3'b001, 32'h22, 5'd4, 32'hFFFF8899, 1'b1, 1'b0, 1'b1);
    ld("lhu20", 3'b101, 32'h20, 5'd5, 32'h0000AABB, 1'b1, 1'b0, 1'b1);
    ld("lw20", 3'b010, 32'h20, 5'd6, 32'h8899AABB, 1'b1, 1'b0, 1'b1);
    ld("ld_f3_011", 3'b011, 32'h20, 5'd7, 32'h00000000, 1'b1, 1'b0, 1'b1);

    st("sw30", 3'b010, 32'h30, 32'h11223344, 1'b0);
    st("sb31", 3'b000, 32'h31, 32'hFFFFFF5A, 1'b0);
    ld("lw30_sb", 3'b010, 32'h30, 5'd8, 32'h11225A44, 1'b1, 1'b0, 1'b1);
    st("sh32", 3'b001, 32'h32, 32'h12347777, 1'b0);
    ld("lw30_sh", 3'b010, 32'h30, 5'd9, 32'h77775A44, 1'b1, 1'b0, 1'b1);
    st("st_f3_011", 3'b011, 32'h30, 32'h00000000, 1'b0);
    ld("lw30_nowr", 3'b010, 32'h30, 5'd10, 32'h77775A44, 1'b1, 1'b0, 1'b1);

    op("src00", 2'b00, 32'h1234, 32'h0, 5'd11, 32'h00001234);
    op("src10", 2'b10, 32'h999, 32'h80, 5'd12, 32'h00000080);
    op("src11", 2'b11, 32'h5, 32'h7, 5'd13, 32'h00000000);

    st("sw_wrap", 3'b010, 32'h1004, 32'hCAFEF00D, 1'b0);
    ld("lw4_wrap", 3'b010, 32'h4, 5'd14, 32'hCAFEF00D, 1'b1, 1'b0, 1'b1);

    st("sw40", 3'b010, 32'h40, 32'h01020304, 1'b0);
`ifdef MISALIGN_CHECK_EN
    st("sw41_mis", 3'b010, 32'h41, 32'hA5B6C7D8, 1'b1);
    ld("lw40_kept", 3'b010, 32'h40, 5'd15, 32'h01020304, 1'b1, 1'b0, 1'b1);
    ld("lh43_mis", 3'b001, 32'h43, 5'd16, 32'h0, 1'b0, 1'b1, 1'b0);
    ld("lbu43", 3'b100, 32'h43, 5'd17, 32'h00000001, 1'b1, 1'b0, 1'b1);
`else
    st("sw41_align", 3'b010, 32'h41, 32'hA5B6C7D8, 1'b0);
    ld("lw40_new", 3'b010, 32'h40, 5'd15, 32'hA5B6C7D8, 1'b1, 1'b0, 1'b1);
    ld("lh43_align", 3'b001, 32'h43, 5'd16, 32'hFFFFA5B6, 1'b1, 1'b0, 1'b1);
    ld("lbu43", 3'b100, 32'h43, 5'd17, 32'h000000A5, 1'b1, 1'b0, 1'b1);
`endif

    // Reset asserted while a store sits in M: the store must be dropped.
    drive(3'b010, 2'b00, 32'h50, 32'h13579BDF, 32'h0, 5'd0, 1'b0, 1'b1);
    @(negedge clk);
    #1 rst = 1'b0;
    #1 chk("arst.ResultW", bus.ResultW, 32'h0);
    @(posedge clk);
    @(negedge clk);
    chk("arst.RegWriteW", {31'h0, bus.RegWriteW}, 32'h0);
    bus.MemWriteM = 1'b0;
    #1 rst = 1'b1;
    ld("lw50_dropped", 3'b010, 32'h50, 5'd18, 32'h00000000, 1'b1, 1'b0, 1'b1);

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("drain.queue", q.size(), 32'h0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
